lector_botones: RTL and testbench



---
 rtl/lector_botones_pkg.sv | 27 ++
 rtl/lector_botones_antirrebote.sv | 49 ++++
 rtl/lector_botones.sv | 75 +++++++
 tb/tb_lector_botones.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lector_botones_pkg.sv
// Button codes shared by the snake input stage, instruction buffer and game FSM.
// Lower code means higher priority when several presses land in the same cycle.
package lector_botones_pkg;

  localparam int unsigned BTN_W   = 3;
  localparam int unsigned NUM_BTN = 5;

  localparam logic [BTN_W-1:0] BTN_NINGUNO = 3'd0;
  localparam logic [BTN_W-1:0] BTN_ARRIBA  = 3'd1;
  localparam logic [BTN_W-1:0] BTN_ABAJO   = 3'd2;
  localparam logic [BTN_W-1:0] BTN_IZQ     = 3'd3;
  localparam logic [BTN_W-1:0] BTN_DER     = 3'd4;
  localparam logic [BTN_W-1:0] BTN_CENTRO  = 3'd5;

  // Bit i of p is the press pulse of button code i+1.
  function automatic logic [BTN_W-1:0] codificar_prioridad(input logic [NUM_BTN-1:0] p);
    logic [BTN_W-1:0] c;
    c = BTN_NINGUNO;
    if (p[0])      c = BTN_ARRIBA;
    else if (p[1]) c = BTN_ABAJO;
    else if (p[2]) c = BTN_IZQ;
    else if (p[3]) c = BTN_DER;
    else if (p[4]) c = BTN_CENTRO;
    return c;
  endfunction

endpackage

// File: rtl/lector_botones_antirrebote.sv
// One button: 2-FF synchronizer, debounce counter, registered press pulse.
// Latency: pulse 2 + DEB_CYCLES cycles after the raw edge; no backpressure.
module antirrebote #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulso
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulso_q, pulso_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    // The counter only runs while the synchronized level disagrees with the accepted one.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync2_q;
      else                   cnt_d    = cnt_q + CW'(1);
    end
    pulso_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulso_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulso_q  <= pulso_d;
    end
  end

  assign pulso = pulso_q;

endmodule

// File: rtl/lector_botones.sv
// Debounces five buttons and emits the latest press code once per game tick.
// Latency: LE registered, one cycle wide, every TICK_CYCLES enabled cycles; no backpressure.
module lector_botones
  import lector_botones_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned TICK_CYCLES = 12500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_arriba,
  input  logic             btn_abajo,
  input  logic             btn_izq,
  input  logic             btn_der,
  input  logic             btn_centro,
  input  logic             habilitar,
  output logic             LE,
  output logic [BTN_W-1:0] boton_pres
);

  localparam int unsigned TW = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [NUM_BTN-1:0] botones;
  logic [NUM_BTN-1:0] pulsos;
  logic [BTN_W-1:0]   codigo;
  logic               terminal;

  logic [TW-1:0]    tick_q, tick_d;
  logic [BTN_W-1:0] pend_q, pend_d;
  logic             le_q, le_d;
  logic [BTN_W-1:0] bp_q, bp_d;

  assign botones = {btn_centro, btn_der, btn_izq, btn_abajo, btn_arriba};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_antirrebote (
      .clk   (clk),
      .rst   (rst),
      .btn_i (botones[i]),
      .pulso (pulsos[i])
    );
  end

  assign codigo = codificar_prioridad(pulsos);

  always_comb begin
    terminal = habilitar && (tick_q == TICK_LAST);
    tick_d   = (habilitar && !terminal) ? tick_q + TW'(1) : '0;
    // A press arriving on the terminal edge survives into the next tick.
    if (codigo != BTN_NINGUNO) pend_d = codigo;
    else if (terminal)         pend_d = BTN_NINGUNO;
    else                       pend_d = pend_q;
    le_d = terminal;
    bp_d = terminal ? pend_q : bp_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q <= '0;
      pend_q <= BTN_NINGUNO;
      le_q   <= 1'b0;
      bp_q   <= BTN_NINGUNO;
    end else begin
      tick_q <= tick_d;
      pend_q <= pend_d;
      le_q   <= le_d;
      bp_q   <= bp_d;
    end
  end

  assign LE         = le_q;
  assign boton_pres = bp_q;

endmodule

// File: tb/tb_lector_botones.sv
// Directed scenarios plus random button activity, checked every cycle against a history-based model.
module tb_lector_botones;

  localparam int DEB  = 4;
  localparam int TICK = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] raw = '0;
  logic       hab = 1'b0;
  logic       LE;
  logic [2:0] boton_pres;

  int checks = 0;
  int errors = 0;

  lector_botones #(.DEB_CYCLES(DEB), .TICK_CYCLES(TICK)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_arriba (raw[0]),
    .btn_abajo  (raw[1]),
    .btn_izq    (raw[2]),
    .btn_der    (raw[3]),
    .btn_centro (raw[4]),
    .habilitar  (hab),
    .LE         (LE),
    .boton_pres (boton_pres)
  );

  always #5 clk = ~clk;

  // Model: raw samples since reset, accepted level per button, edge of last accepted change.
  bit [4:0] hist[$];
  bit [4:0] m_st, m_pul;
  int       lastflip[5];
  int       m_tick;
  bit [2:0] m_pend, m_bp;
  bit       m_le;

  function automatic void model_reset();
    hist.delete();
    m_st = '0; m_pul = '0;
    for (int b = 0; b < 5; b++) lastflip[b] = -1;
    m_tick = 0; m_pend = 0; m_bp = 0; m_le = 0;
  endfunction

  // Level seen by the debouncer at edge e: the raw value sampled two edges earlier.
  function automatic bit seen_at(int e, int b);
    return (e >= 2) ? hist[e-2][b] : 1'b0;
  endfunction

  function automatic void model_step(bit [4:0] r, bit h);
    int       n;
    bit [2:0] code;
    bit       term, all_diff;
    bit [4:0] new_pul;
    n = hist.size();
    code = 0;
    for (int b = 4; b >= 0; b--) if (m_pul[b]) code = 3'(b + 1);
    term = h && (m_tick == TICK - 1);
    m_le = term;
    if (term) m_bp = m_pend;
    if (code != 0) m_pend = code;
    else if (term) m_pend = 0;
    m_tick = (h && !term) ? m_tick + 1 : 0;
    new_pul = '0;
    for (int b = 0; b < 5; b++) begin
      // Accept a new level once the last DEB observations since the previous change all disagree.
      all_diff = 1;
      for (int j = 0; j < DEB; j++) begin
        if (n - j <= lastflip[b] || n - j < 0) all_diff = 0;
        else if (seen_at(n - j, b) == m_st[b]) all_diff = 0;
      end
      if (all_diff) begin
        m_st[b] = ~m_st[b];
        new_pul[b] = m_st[b];
        lastflip[b] = n;
      end
    end
    m_pul = new_pul;
    hist.push_back(r);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst) model_reset();
      else model_step(raw, hab);
      #1;
      chk("model_le", int'(LE), int'(m_le));
      chk("model_boton_pres", int'(boton_pres), int'(m_bp));
    end
  endtask

  task automatic wait_le(input string tag, output int code);
    bit got;
    got = 0;
    code = -1;
    for (int i = 0; i < 4 * TICK; i++) begin
      cyc(1);
      if (LE === 1'b1) begin got = 1; break; end
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s_timeout: observed no LE expected LE within %0d cycles", tag, 4 * TICK);
    end
    if (got) code = int'(boton_pres);
  endtask

  int code, nz, n;

  initial begin
    model_reset();
    #1;
    chk("reset_le", int'(LE), 0);
    chk("reset_boton_pres", int'(boton_pres), 0);
    cyc(3);
    rst = 1'b1;
    hab = 1'b1;
    wait_le("first", code);
    chk("first_code", code, 0);

    // Glitch shorter than the debounce window.
    raw[3] = 1'b1; cyc(3); raw[3] = 1'b0;
    wait_le("glitch", code);
    chk("glitch_code", code, 0);

    // Bounce for 20 cycles, then hold.
    for (int i = 0; i < 5; i++) begin
      raw[0] = 1'b1; cyc(2); raw[0] = 1'b0; cyc(2);
    end
    raw[0] = 1'b1;
    nz = 0;
    for (int i = 0; i < 3; i++) begin
      wait_le("bounce", code);
      if (code != 0) begin
        nz++;
        chk("bounce_code", code, 1);
      end
    end
    chk("bounce_events", nz, 1);
    raw[0] = 1'b0;
    cyc(8);

    // Overwrite within one tick, then simultaneous presses.
    wait_le("pre_overwrite", code);
    raw[2] = 1'b1; cyc(5); raw[2] = 1'b0;
    raw[3] = 1'b1; cyc(5); raw[3] = 1'b0;
    wait_le("overwrite", code);
    chk("overwrite_code", code, 4);
    raw[1] = 1'b1; raw[4] = 1'b1; cyc(6); raw[1] = 1'b0; raw[4] = 1'b0;
    wait_le("simultaneous", code);
    chk("simultaneous_code", code, 2);

    // Centro press lands on the terminal-count edge.
    raw[1] = 1'b1; cyc(6); raw[1] = 1'b0;
    cyc(3);
    raw[4] = 1'b1; cyc(6); raw[4] = 1'b0;
    wait_le("terminal_a", code);
    chk("terminal_prior_code", code, 2);
    wait_le("terminal_b", code);
    chk("terminal_next_code", code, 5);

    // Drop habilitar exactly in the terminal-count cycle.
    for (int i = 0; i < 2 * TICK && m_tick != TICK - 1; i++) cyc(1);
    chk("align_terminal_tick", m_tick, TICK - 1);
    hab = 1'b0; cyc(1);
    chk("dropped_tick_le", int'(LE), 0);

    // Long disable with one press, then re-enable.
    nz = 0;
    for (int i = 0; i < 100; i++) begin
      raw[3] = (i >= 40 && i < 50);
      cyc(1);
      if (LE === 1'b1) nz++;
    end
    chk("disabled_le_count", nz, 0);
    hab = 1'b1;
    n = 0;
    for (int i = 0; i < 3 * TICK; i++) begin
      cyc(1); n++;
      if (LE === 1'b1) break;
    end
    chk("enable_latency", n, TICK);
    chk("enable_code", int'(boton_pres), 4);

    // Asynchronous reset while LE=1 carrying 3; izq stays held across reset.
    raw[2] = 1'b1;
    wait_le("pre_reset", code);
    chk("pre_reset_code", code, 3);
    chk("pre_reset_le", int'(LE), 1);
    rst = 1'b0;
    #1;
    chk("async_reset_le", int'(LE), 0);
    chk("async_reset_boton_pres", int'(boton_pres), 0);
    cyc(5);
    rst = 1'b1;
    wait_le("post_reset", code);
    chk("held_through_reset_code", code, 3);
    raw[2] = 1'b0;

    // Random activity.
    for (int i = 0; i < 2500; i++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 24) == 0) raw[b] = ~raw[b];
      if ($urandom_range(0, 199) == 0) hab = ~hab;
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
